pipeline_hazard_ctrl: RTL and testbench

Central sequencer for the 5-stage RISC-V pipeline. It drives the enable/clear pairs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC enable/select. It resolves load-use and taken-branch hazards. It also runs the Avalon-MM data-memory transaction for the instruction held in EX/MEM, freezing the pipeline until the bus completes.

---
 rtl/pipeline_hazard_ctrl.sv | 172 +++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Central sequencer for a 5-stage RISC-V pipeline. Drives the enable/clear
// pairs of the IF/ID, ID/EX, EX/MEM and MEM/WB registers plus the PC
// enable/select, resolves load-use and taken-branch hazards, and runs the
// Avalon-MM data-memory transaction for the instruction held in EX/MEM,
// freezing the whole pipeline until the bus completes.
//
// Ports:
//   CLK, RST                        clock, synchronous active-high reset
//   id_rs1, id_rs2                  source registers of the instruction in ID
//   ex_rd, ex_memread               destination / load flag of the instruction in EX
//   mem_branch, mem_zero            EX/MEM branch and zero flags
//   mem_memread, mem_memwrite       EX/MEM load / store flags
//   avm_waitrequest, avm_readdatavalid  Avalon-MM slave handshake
//   pc_en, pc_sel                   PC update enable, 1 = take branch target
//   *_en, *_clr                     pipeline register enables / clears (clear wins)
//   avm_read, avm_write             registered Avalon requests
//   bus_err                         sticky registered watchdog error
module pipeline_hazard_ctrl #(
    parameter int MAX_WAIT = 64
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_memread,
    input  logic       mem_branch,
    input  logic       mem_zero,
    input  logic       mem_memread,
    input  logic       mem_memwrite,
    input  logic       avm_waitrequest,
    input  logic       avm_readdatavalid,
    output logic       pc_en,
    output logic       pc_sel,
    output logic       ifid_en,
    output logic       idex_en,
    output logic       exmem_en,
    output logic       memwb_en,
    output logic       ifid_clr,
    output logic       idex_clr,
    output logic       exmem_clr,
    output logic       memwb_clr,
    output logic       avm_read,
    output logic       avm_write,
    output logic       bus_err
);

    localparam int              WDW     = $clog2(MAX_WAIT + 1);
    localparam logic [WDW-1:0]  WD_LAST = WDW'(MAX_WAIT - 1);

    // Control word layout: {pc_en, pc_sel, ifid_en, idex_en, exmem_en, memwb_en,
    //                       ifid_clr, idex_clr, exmem_clr, memwb_clr}
    localparam logic [9:0] CTL_FREEZE = 10'b00_0000_0000;
    localparam logic [9:0] CTL_RESET  = 10'b00_0000_1111;
    localparam logic [9:0] CTL_BRANCH = 10'b11_1111_1110;
    localparam logic [9:0] CTL_STALL  = 10'b00_0111_0100;
    localparam logic [9:0] CTL_FLOW   = 10'b10_1111_0000;

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        MEM_REQ  = 3'd1,
        MEM_DATA = 3'd2,
        MEM_DONE = 3'd3,
        ERR      = 3'd4
    } stateT;

    stateT          stateR;
    logic [WDW-1:0] wdogR;
    logic           memTrigS;
    logic           takenS;
    logic           loadUseS;
    logic           busDoneS;
    logic [9:0]     ctlS;

    // Hazard priority: a taken branch flushes the younger instructions, which
    // also removes any load-use dependency they had, so it wins over the stall.
    function automatic logic [9:0] hazardCtl(input logic taken, input logic loadUse);
        logic [9:0] v;
        if (taken) begin
            v = CTL_BRANCH;
        end else if (loadUse) begin
            v = CTL_STALL;
        end else begin
            v = CTL_FLOW;
        end
        return v;
    endfunction

    assign memTrigS = mem_memread | mem_memwrite;
    assign takenS   = mem_branch & mem_zero;
    assign loadUseS = ex_memread & (ex_rd != 5'd0) &
                      ((ex_rd == id_rs1) | (ex_rd == id_rs2));

    // Bus completion for the current cycle; a combined load+store completes as a read.
    always_comb begin
        busDoneS = 1'b0;
        case (stateR)
            MEM_REQ:  busDoneS = ~avm_waitrequest & (~avm_read | avm_readdatavalid);
            MEM_DATA: busDoneS = avm_readdatavalid;
            default:  busDoneS = 1'b0;
        endcase
    end

    // Pipeline enables/clears and PC select from state, hazards and reset.
    always_comb begin
        ctlS = CTL_FREEZE;
        if (RST) begin
            ctlS = CTL_RESET;
        end else begin
            case (stateR)
                RUN:      ctlS = memTrigS ? CTL_FREEZE : hazardCtl(takenS, loadUseS);
                MEM_DONE: ctlS = hazardCtl(takenS, loadUseS);
                default:  ctlS = CTL_FREEZE;
            endcase
        end
    end

    assign {pc_en, pc_sel, ifid_en, idex_en, exmem_en, memwb_en,
            ifid_clr, idex_clr, exmem_clr, memwb_clr} = ctlS;

    // Sequencer state, Avalon requests, watchdog and sticky bus error.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stateR    <= RUN;
            avm_read  <= 1'b0;
            avm_write <= 1'b0;
            bus_err   <= 1'b0;
            wdogR     <= '0;
        end else begin
            case (stateR)
                RUN: begin
                    if (memTrigS) begin
                        stateR    <= MEM_REQ;
                        avm_read  <= mem_memread;
                        avm_write <= mem_memwrite;
                        wdogR     <= '0;
                    end
                end
                MEM_REQ, MEM_DATA: begin
                    if (busDoneS) begin
                        stateR    <= MEM_DONE;
                        avm_read  <= 1'b0;
                        avm_write <= 1'b0;
                    end else if (wdogR == WD_LAST) begin
                        // This cycle is the last one allowed without completion.
                        stateR    <= ERR;
                        bus_err   <= 1'b1;
                        avm_read  <= 1'b0;
                        avm_write <= 1'b0;
                    end else begin
                        wdogR <= wdogR + WDW'(1);
                        if ((stateR == MEM_REQ) && !avm_waitrequest) begin
                            // Read accepted, data still outstanding.
                            stateR    <= MEM_DATA;
                            avm_read  <= 1'b0;
                            avm_write <= 1'b0;
                        end
                    end
                end
                MEM_DONE: stateR <= RUN;
                ERR:      stateR <= ERR;
                default: begin
                    stateR    <= RUN;
                    avm_read  <= 1'b0;
                    avm_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios followed by
// randomized cycles, all compared against a transaction-level reference model.
module tb_pipeline_hazard_ctrl;

    localparam int MAXW = 4;

    logic       CLK = 1'b0;
    logic       RST;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       ex_memread, mem_branch, mem_zero, mem_memread, mem_memwrite;
    logic       avm_waitrequest, avm_readdatavalid;
    logic       pc_en, pc_sel, ifid_en, idex_en, exmem_en, memwb_en;
    logic       ifid_clr, idex_clr, exmem_clr, memwb_clr;
    logic       avm_read, avm_write, bus_err;
    logic [9:0] ctlObs;

    int tests = 0;
    int fails = 0;
    int wrSeen, rdSeen;

    // Reference model: transaction outstanding, data phase pending, cycles spent,
    // one-cycle completion window, error latch, and expected bus request levels.
    bit mBusy, mAwaitData, mIsRead, mDone, mErr, mReqRd, mReqWr;
    int mCycles;

    pipeline_hazard_ctrl #(.MAX_WAIT(MAXW)) dut (
        .CLK(CLK), .RST(RST),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd), .ex_memread(ex_memread),
        .mem_branch(mem_branch), .mem_zero(mem_zero),
        .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
        .avm_waitrequest(avm_waitrequest), .avm_readdatavalid(avm_readdatavalid),
        .pc_en(pc_en), .pc_sel(pc_sel),
        .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_clr(ifid_clr), .idex_clr(idex_clr), .exmem_clr(exmem_clr), .memwb_clr(memwb_clr),
        .avm_read(avm_read), .avm_write(avm_write), .bus_err(bus_err)
    );

    always #5 CLK = ~CLK;

    assign ctlObs = {pc_en, pc_sel, ifid_en, idex_en, exmem_en, memwb_en,
                     ifid_clr, idex_clr, exmem_clr, memwb_clr};

    task automatic modelStep();
        bit fin;
        if (RST) begin
            mBusy = 0; mAwaitData = 0; mDone = 0; mErr = 0; mReqRd = 0; mReqWr = 0; mCycles = 0;
        end else if (mErr) begin
            mErr = 1;
        end else if (mBusy) begin
            if (mAwaitData) fin = avm_readdatavalid;
            else            fin = !avm_waitrequest && (!mIsRead || avm_readdatavalid);
            if (fin) begin
                mBusy = 0; mAwaitData = 0; mDone = 1; mReqRd = 0; mReqWr = 0;
            end else if (mCycles + 1 >= MAXW) begin
                mBusy = 0; mErr = 1; mReqRd = 0; mReqWr = 0;
            end else begin
                mCycles++;
                if (!mAwaitData && !avm_waitrequest) begin
                    mAwaitData = 1; mReqRd = 0; mReqWr = 0;
                end
            end
        end else if (mDone) begin
            mDone = 0;
        end else if (mem_memread || mem_memwrite) begin
            mBusy = 1; mAwaitData = 0; mCycles = 0;
            mIsRead = mem_memread; mReqRd = mem_memread; mReqWr = mem_memwrite;
        end else begin
            mDone = 0;
        end
    endtask

    // One clock: check mid-cycle against the model, then advance the model at the edge.
    task automatic cyc(input string tag);
        logic [9:0] exp, mask;
        bit taken, lu;
        #3;
        mask  = 10'h3FF;
        taken = mem_branch && mem_zero;
        lu    = ex_memread && (ex_rd != 5'd0) && (ex_rd == id_rs1 || ex_rd == id_rs2);
        if (RST)                                          exp = 10'b00_0000_1111;
        else if (mErr || mBusy)                           exp = 10'b0;
        else if (!mDone && (mem_memread || mem_memwrite)) exp = 10'b0;
        else if (taken)                                   exp = 10'b11_1111_1110;
        else if (lu) begin
            exp  = 10'b00_0011_0100;
            mask = 10'b11_1011_1111;  // idex_en is irrelevant while idex_clr is set
        end
        else                                              exp = 10'b10_1111_0000;
        wrSeen += int'(avm_write);
        rdSeen += int'(avm_read);
        tests++;
        assert ((ctlObs & mask) === (exp & mask)) else begin
            fails++;
            $error("FAIL %s ctl got %b want %b", tag, ctlObs & mask, exp & mask);
        end
        tests++;
        assert ({avm_read, avm_write, bus_err} === {mReqRd, mReqWr, mErr}) else begin
            fails++;
            $error("FAIL %s bus rd/wr/err got %b want %b", tag,
                   {avm_read, avm_write, bus_err}, {mReqRd, mReqWr, mErr});
        end
        @(posedge CLK);
        modelStep();
        #1;
    endtask

    task automatic idleInputs();
        id_rs1 = 5'd1; id_rs2 = 5'd2; ex_rd = 5'd3; ex_memread = 1'b0;
        mem_branch = 1'b0; mem_zero = 1'b0; mem_memread = 1'b0; mem_memwrite = 1'b0;
        avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        idleInputs();
        mBusy = 0; mAwaitData = 0; mIsRead = 0; mDone = 0; mErr = 0;
        mReqRd = 0; mReqWr = 0; mCycles = 0;
        @(posedge CLK);
        modelStep();
        #1;
        cyc("reset_hold");
        RST = 1'b0;
        cyc("idle");
        cyc("idle2");

        // Load-use stalls, and the x0 exception.
        ex_memread = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5;
        cyc("loaduse_rs2");
        ex_rd = 5'd0; id_rs2 = 5'd0;
        cyc("loaduse_x0");
        ex_rd = 5'd7; id_rs1 = 5'd7; id_rs2 = 5'd2;
        cyc("loaduse_rs1");

        // Taken branch wins over a simultaneous load-use match.
        mem_branch = 1'b1; mem_zero = 1'b1;
        cyc("branch_over_lu");
        tests++;
        assert (pc_en === 1'b1 && pc_sel === 1'b1 && ifid_clr === 1'b1) else begin
            fails++;
            $error("FAIL branch_wins got pc_en=%b pc_sel=%b ifid_clr=%b want 1 1 1",
                   pc_en, pc_sel, ifid_clr);
        end
        mem_zero = 1'b0;
        cyc("branch_not_taken");
        idleInputs();

        // Store held off by waitrequest for 3 cycles.
        mem_memwrite = 1'b1; avm_waitrequest = 1'b1;
        wrSeen = 0;
        cyc("st_trigger");
        for (int i = 0; i < 3; i++) cyc("st_wait");
        avm_waitrequest = 1'b0;
        cyc("st_accept");
        cyc("st_done");
        tests++;
        assert (wrSeen == 4) else begin
            fails++;
            $error("FAIL st_write_len got %0d want 4", wrSeen);
        end
        mem_memwrite = 1'b0;
        cyc("st_run");

        // Load accepted at once, data two cycles later.
        mem_memread = 1'b1;
        rdSeen = 0;
        cyc("ld_trigger");
        cyc("ld_accept");
        cyc("ld_data_wait");
        avm_readdatavalid = 1'b1;
        cyc("ld_data");
        avm_readdatavalid = 1'b0;
        cyc("ld_done");
        tests++;
        assert (rdSeen == 1) else begin
            fails++;
            $error("FAIL ld_read_len got %0d want 1", rdSeen);
        end
        mem_memread = 1'b0;

        // Load with data coincident with acceptance.
        mem_memread = 1'b1;
        cyc("ld2_trigger");
        avm_readdatavalid = 1'b1;
        cyc("ld2_accept_data");
        avm_readdatavalid = 1'b0;
        cyc("ld2_done");
        mem_memread = 1'b0;
        cyc("ld2_run");

        // Combined load+store completes as a read.
        mem_memread = 1'b1; mem_memwrite = 1'b1;
        cyc("ldst_trigger");
        cyc("ldst_accept");
        avm_readdatavalid = 1'b1;
        cyc("ldst_data");
        idleInputs();
        cyc("ldst_done");

        // Watchdog: waitrequest stuck high.
        mem_memread = 1'b1; avm_waitrequest = 1'b1;
        cyc("wd_trigger");
        for (int i = 0; i < MAXW; i++) cyc("wd_wait");
        tests++;
        assert (bus_err === 1'b1 && avm_read === 1'b0) else begin
            fails++;
            $error("FAIL wd_err got bus_err=%b avm_read=%b want 1 0", bus_err, avm_read);
        end
        cyc("err_hold");
        idleInputs();
        cyc("err_hold2");
        RST = 1'b1;
        cyc("err_reset");
        RST = 1'b0;
        cyc("after_reset");

        // Reset mid-transaction abandons the bus request.
        mem_memwrite = 1'b1; avm_waitrequest = 1'b1;
        cyc("abort_trigger");
        cyc("abort_wait");
        RST = 1'b1;
        cyc("abort_rst");
        RST = 1'b0;
        idleInputs();
        cyc("abort_run");

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            RST               = ($urandom_range(0, 24) == 0);
            id_rs1            = 5'($urandom_range(0, 3));
            id_rs2            = 5'($urandom_range(0, 3));
            ex_rd             = 5'($urandom_range(0, 3));
            ex_memread        = 1'($urandom_range(0, 1));
            mem_branch        = 1'($urandom_range(0, 1));
            mem_zero          = 1'($urandom_range(0, 1));
            mem_memread       = ($urandom_range(0, 4) == 0);
            mem_memwrite      = ($urandom_range(0, 4) == 0);
            avm_waitrequest   = 1'($urandom_range(0, 1));
            avm_readdatavalid = ($urandom_range(0, 2) == 0);
            cyc("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
